// File: rtl/clk_rst_seq_pkg.sv
// Shared types and defaults for the multi-channel reset sequencer.
package clk_rst_pkg;

    localparam int CLK_RST_CNT_W = 8;

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN
    } clk_rst_seq_state_t;

endpackage

// File: rtl/clk_rst_seq_debounce.sv
// Synchroniser chain for the asynchronous external reset request, followed by a
// saturating run-length counter; deb_req is high while the request has been stable.
module clk_rst_debounce
    import clk_rst_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYC     = 3,
    parameter int CNT_W       = CLK_RST_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic ext_rst_req,
    output logic deb_req
);

    localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEB_CYC);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       deb_cnt_q, deb_cnt_d;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], ext_rst_req};
        deb_cnt_d = deb_cnt_q;
        if (!sync_q[SYNC_STAGES-1]) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q != DEB_TC) begin
            deb_cnt_d = deb_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            deb_cnt_q <= '0;
        end else begin
            sync_q    <= sync_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign deb_req = (deb_cnt_q == DEB_TC);

endmodule

// File: rtl/clk_rst_seq.sv
// Staggered reset release for NUM_CH downstream domains, with debounced external
// re-trigger and per-channel soft resets once the sequence has completed.
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CLK_RST_CNT_W,
    parameter int HOLD_CYC    = 8,
    parameter int STAGE_DLY   = 4,
    parameter int SOFT_CYC    = 6,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYC     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_rst_req,
    input  logic [NUM_CH-1:0] ch_rst_req,
    output logic [NUM_CH-1:0] ch_rst_n,
    output logic              seq_busy,
    output logic              seq_done
);

    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int MAX_AB  = (HOLD_CYC > STAGE_DLY) ? HOLD_CYC : STAGE_DLY;
    localparam int MAX_CD  = (SOFT_CYC > DEB_CYC) ? SOFT_CYC : DEB_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;

    localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAGE_TC  = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0] SOFT_LOAD = CNT_W'(SOFT_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("clk_rst_seq: NUM_CH must be within 1..16");
    end
    if (HOLD_CYC < 1 || STAGE_DLY < 1 || SOFT_CYC < 1 || DEB_CYC < 1 || SYNC_STAGES < 2) begin : g_bad_cycles
        $error("clk_rst_seq: cycle parameters out of range");
    end
    if ((64'd1 << CNT_W) <= 64'(MAX_CYC) || (1 << $clog2(NUM_CH)) < NUM_CH) begin : g_bad_width
        $error("clk_rst_seq: CNT_W too narrow for the configured cycle counts");
    end

    clk_rst_seq_state_t state_q, state_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]   stg_cnt_q, stg_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_CH-1:0]  ch_rst_n_q, ch_rst_n_d;
    logic               seq_busy_q, seq_busy_d;
    logic               seq_done_q, seq_done_d;
    logic [NUM_CH-1:0]  rel_mask;
    logic [NUM_CH-1:0]  soft_idle;
    logic               deb_req;

    clk_rst_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYC     (DEB_CYC),
        .CNT_W       (CNT_W)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .ext_rst_req (ext_rst_req),
        .deb_req     (deb_req)
    );

    // A debounced request pins the FSM in HOLD with cleared counters for as long as it lasts.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        stg_cnt_d  = stg_cnt_q;
        idx_d      = idx_q;
        if (deb_req) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
            stg_cnt_d  = '0;
            idx_d      = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (hold_cnt_q == HOLD_TC) begin
                        state_d    = RELEASE;
                        hold_cnt_d = '0;
                        stg_cnt_d  = '0;
                        idx_d      = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (idx_q == IDX_LAST) begin
                        state_d   = RUN;
                        stg_cnt_d = '0;
                    end else if (stg_cnt_q == STAGE_TC) begin
                        stg_cnt_d = '0;
                        idx_d     = idx_q + IDX_W'(1);
                    end else begin
                        stg_cnt_d = stg_cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end
    end

    always_comb begin
        rel_mask = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            rel_mask[k] = (state_q == RUN) || ((state_q == RELEASE) && (k <= int'(idx_q)));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_soft
        logic [CNT_W-1:0] soft_cnt_q, soft_cnt_d;

        // Soft requests only count in RUN; a repeat request reloads the full low period.
        always_comb begin
            soft_cnt_d = soft_cnt_q;
            if (deb_req || state_q != RUN) begin
                soft_cnt_d = '0;
            end else if (ch_rst_req[i]) begin
                soft_cnt_d = SOFT_LOAD;
            end else if (soft_cnt_q != '0) begin
                soft_cnt_d = soft_cnt_q - CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                soft_cnt_q <= '0;
            end else begin
                soft_cnt_q <= soft_cnt_d;
            end
        end

        assign soft_idle[i] = (soft_cnt_q == '0);
    end

    // Outputs are registered one cycle behind the FSM/counter state they reflect.
    always_comb begin
        ch_rst_n_d = rel_mask & soft_idle;
        seq_busy_d = (state_q != RUN);
        seq_done_d = (state_q == RUN) && seq_busy_q;
        if (deb_req) begin
            ch_rst_n_d = '0;
            seq_busy_d = 1'b1;
            seq_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HOLD;
            hold_cnt_q <= '0;
            stg_cnt_q  <= '0;
            idx_q      <= '0;
            ch_rst_n_q <= '0;
            seq_busy_q <= 1'b1;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            stg_cnt_q  <= stg_cnt_d;
            idx_q      <= idx_d;
            ch_rst_n_q <= ch_rst_n_d;
            seq_busy_q <= seq_busy_d;
            seq_done_q <= seq_done_d;
        end
    end

    assign ch_rst_n = ch_rst_n_q;
    assign seq_busy = seq_busy_q;
    assign seq_done = seq_done_q;

endmodule
